dsi_lanes_distributor: RTL and testbench



---
 rtl/dsi_lanes_distributor_pkg.sv | 30 +++
 rtl/dsi_byte_buffer.sv | 70 +++++++
 rtl/dsi_lanes_distributor.sv | 162 ++++++++++++++++
 tb/tb_dsi_lanes_distributor.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsi_lanes_distributor_pkg.sv
// Shared DSI distributor definitions: lane limits, byte-count widths, FSM encoding.
// No logic; imported by the distributor top and its byte buffer.
// No backpressure (package only).
package dsi_lanes_distributor_pkg;

    localparam int DSI_LANES_MAX = 4;
    localparam int DSI_BYTES_W   = 3;
    localparam int DSI_CNT_W     = 4;
    localparam int DSI_BUF_BYTES = 8;

    localparam logic [DSI_CNT_W-1:0] DSI_WORD_BYTES = DSI_CNT_W'(4);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } dsi_state_e;

    // Bytes to drain in DRAIN: whatever is left, capped at the lane count.
    function automatic logic [DSI_BYTES_W-1:0] dsi_min_bytes(
        input logic [DSI_CNT_W-1:0]   cnt,
        input logic [DSI_BYTES_W-1:0] n
    );
        if (cnt < {1'b0, n}) begin
            return cnt[DSI_BYTES_W-1:0];
        end
        return n;
    endfunction

endpackage

// File: rtl/dsi_byte_buffer.sv
// 8-byte elastic shift buffer: drains from position 0, appends at the fill level.
// Zero latency: head_o/cnt_o reflect the registered contents.
// No flow control of its own; the caller keeps (cnt - drain) <= 4 before appending.
module dsi_byte_buffer
    import dsi_lanes_distributor_pkg::*;
#(
    parameter int BUF_BYTES = DSI_BUF_BYTES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   append_vld_i,
    input  logic [31:0]            append_dat_i,
    input  logic [DSI_BYTES_W-1:0] append_n_i,
    input  logic [DSI_BYTES_W-1:0] drain_n_i,
    output logic [DSI_CNT_W-1:0]   cnt_o,
    output logic [31:0]            head_o
);

    localparam int AW = 3;

    if (BUF_BYTES != 8) begin : g_bad_depth
        $error("dsi_byte_buffer: BUF_BYTES must be 8");
    end

    logic [7:0]           mem_q [BUF_BYTES];
    logic [7:0]           mem_d [BUF_BYTES];
    logic [DSI_CNT_W-1:0] cnt_q, cnt_d;
    logic [DSI_CNT_W-1:0] rem, src, dst;

    always_comb begin
        rem   = cnt_q - {1'b0, drain_n_i};
        src   = '0;
        dst   = '0;
        for (int k = 0; k < BUF_BYTES; k++) begin
            mem_d[k] = 8'h00;
            src      = DSI_CNT_W'(k) + {1'b0, drain_n_i};
            if (!src[AW]) begin
                mem_d[k] = mem_q[src[AW-1:0]];
            end
        end
        // Append lands on top of the already-shifted contents.
        if (append_vld_i) begin
            for (int j = 0; j < 4; j++) begin
                dst = rem + DSI_CNT_W'(j);
                if ((DSI_BYTES_W'(j) < append_n_i) && !dst[AW]) begin
                    mem_d[dst[AW-1:0]] = append_dat_i[8*j +: 8];
                end
            end
        end
        cnt_d = append_vld_i ? (rem + {1'b0, append_n_i}) : rem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int k = 0; k < BUF_BYTES; k++) begin
                mem_q[k] <= 8'h00;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int k = 0; k < BUF_BYTES; k++) begin
                mem_q[k] <= mem_d[k];
            end
        end
    end

    assign cnt_o  = cnt_q;
    assign head_o = {mem_q[3], mem_q[2], mem_q[1], mem_q[0]};

endmodule

// File: rtl/dsi_lanes_distributor.sv
// Splits a gap-free 32-bit byte stream across 1..4 DSI lanes; DSI_DISTR_STATS_EN adds burst_count.
// One cycle from drain decision to registered lane_data/lane_valid.
// data_read only when the buffer has room; a burst never stalls, starvation sets sticky underflow.
module dsi_lanes_distributor
    import dsi_lanes_distributor_pkg::*;
#(
    parameter int LANES_MAX = DSI_LANES_MAX,
    parameter int BUF_BYTES = DSI_BUF_BYTES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             lanes_number,
    input  logic [31:0]            data_in,
    input  logic [2:0]             data_bytes,
    input  logic                   data_last,
    input  logic                   data_valid,
    output logic                   data_read,
    input  logic                   lanes_ready,
    output logic [8*LANES_MAX-1:0] lane_data,
    output logic [LANES_MAX-1:0]   lane_valid,
    output logic                   hs_active,
    output logic                   underflow,
`ifdef DSI_DISTR_STATS_EN
    output logic [15:0]            burst_count,
`endif
    input  logic                   clear_underflow
);

    if (LANES_MAX < 1 || LANES_MAX > DSI_LANES_MAX) begin : g_bad_lanes
        $error("dsi_lanes_distributor: LANES_MAX must be 1..4");
    end

    dsi_state_e             state_q, state_d;
    logic [DSI_BYTES_W-1:0] n_q, n_d, n_sel, drain_n;
    logic [DSI_CNT_W-1:0]   cnt, cnt_left;
    logic [31:0]            head;
    logic                   underflow_set, burst_end;

    logic [8*LANES_MAX-1:0] lane_data_q, lane_data_d;
    logic [LANES_MAX-1:0]   lane_valid_q, lane_valid_d;
    logic                   hs_q, hs_d, uf_q, uf_d, end_q;

    dsi_byte_buffer #(
        .BUF_BYTES (BUF_BYTES)
    ) u_buf (
        .clk          (clk),
        .rst_n        (reset_n),
        .append_vld_i (data_read),
        .append_dat_i (data_in),
        .append_n_i   (data_bytes),
        .drain_n_i    (drain_n),
        .cnt_o        (cnt),
        .head_o       (head)
    );

    always_comb begin
        n_sel = {1'b0, lanes_number} + 3'd1;
        if (n_sel > DSI_BYTES_W'(LANES_MAX)) begin
            n_sel = DSI_BYTES_W'(LANES_MAX);
        end
    end

    always_comb begin
        drain_n       = '0;
        underflow_set = 1'b0;
        burst_end     = 1'b0;
        state_d       = state_q;
        n_d           = n_q;

        case (state_q)
            ST_ACTIVE: begin
                if (lanes_ready) begin
                    if (cnt >= {1'b0, n_q}) begin
                        drain_n = n_q;
                    end else begin
                        underflow_set = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (lanes_ready) begin
                    drain_n = dsi_min_bytes(cnt, n_q);
                end
            end
            default: ;
        endcase

        cnt_left  = cnt - {1'b0, drain_n};
        data_read = data_valid && (cnt_left <= DSI_WORD_BYTES) && (state_q != ST_DRAIN);

        case (state_q)
            ST_IDLE: begin
                if (data_read) begin
                    n_d     = n_sel;
                    state_d = data_last ? ST_DRAIN : ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (data_read && data_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_left == '0) begin
                    state_d   = ST_IDLE;
                    burst_end = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < LANES_MAX; i++) begin
            lane_valid_d[i]       = DSI_BYTES_W'(i) < drain_n;
            lane_data_d[8*i +: 8] = lane_valid_d[i] ? head[8*i +: 8] : 8'h00;
        end
        // hs_active stays up through the final DRAIN output cycle, then drops.
        hs_d = (drain_n != '0) || (hs_q && !end_q);
        uf_d = clear_underflow ? 1'b0 : (uf_q || underflow_set);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            lane_data_q  <= '0;
            lane_valid_q <= '0;
            hs_q         <= 1'b0;
            uf_q         <= 1'b0;
            end_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            lane_data_q  <= lane_data_d;
            lane_valid_q <= lane_valid_d;
            hs_q         <= hs_d;
            uf_q         <= uf_d;
            end_q        <= burst_end;
        end
    end

    assign lane_data  = lane_data_q;
    assign lane_valid = lane_valid_q;
    assign hs_active  = hs_q;
    assign underflow  = uf_q;

`ifdef DSI_DISTR_STATS_EN
    logic [15:0] burst_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_cnt_q <= '0;
        end else if (burst_end && (burst_cnt_q != 16'hFFFF)) begin
            burst_cnt_q <= burst_cnt_q + 16'd1;
        end
    end

    assign burst_count = burst_cnt_q;
`endif

endmodule

// File: tb/tb_dsi_lanes_distributor.sv
// Bench for dsi_lanes_distributor: directed scenarios plus randomized bursts checked
// against a byte-queue reference model and an in-order byte scoreboard.
module tb_dsi_lanes_distributor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  lanes_number;
    logic [31:0] data_in;
    logic [2:0]  data_bytes;
    logic        data_last;
    logic        data_valid;
    logic        data_read;
    logic        lanes_ready;
    logic [31:0] lane_data;
    logic [3:0]  lane_valid;
    logic        hs_active;
    logic        underflow;
    logic        clear_underflow;
`ifdef DSI_DISTR_STATS_EN
    logic [15:0] burst_count;
    int          m_bursts;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: buffered bytes, burst phase flags and expected registered outputs.
    logic [7:0]  mq[$];
    logic [7:0]  sb[$];
    bit          m_burst, m_last, m_fin_prev;
    int          m_n;
    logic [31:0] e_data;
    logic [3:0]  e_valid;
    logic        e_hs, e_uf;
    bit          exp_rd, obs_rd;
    bit          rnd_rdy, rnd_ln, rnd_clr;

    always #5 clk = ~clk;

    dsi_lanes_distributor #(
        .LANES_MAX (4),
        .BUF_BYTES (8)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .lanes_number    (lanes_number),
        .data_in         (data_in),
        .data_bytes      (data_bytes),
        .data_last       (data_last),
        .data_valid      (data_valid),
        .data_read       (data_read),
        .lanes_ready     (lanes_ready),
        .lane_data       (lane_data),
        .lane_valid      (lane_valid),
        .hs_active       (hs_active),
        .underflow       (underflow),
`ifdef DSI_DISTR_STATS_EN
        .burst_count     (burst_count),
`endif
        .clear_underflow (clear_underflow)
    );

    function automatic int m_drain();
        int c = mq.size();
        if (!m_burst || !lanes_ready) return 0;
        if (!m_last) return (c >= m_n) ? m_n : 0;
        return (c < m_n) ? c : m_n;
    endfunction

    function automatic bit m_read();
        return data_valid && ((mq.size() - m_drain()) <= 4) && !(m_burst && m_last);
    endfunction

    task automatic m_reset();
        mq.delete();
        sb.delete();
        m_burst = 0; m_last = 0; m_fin_prev = 0; m_n = 1;
        e_data = '0; e_valid = '0; e_hs = 1'b0; e_uf = 1'b0;
`ifdef DSI_DISTR_STATS_EN
        m_bursts = 0;
`endif
    endtask

    task automatic m_clock();
        int d;
        bit rd, was_drain, ufset, fin;
        d         = m_drain();
        rd        = m_read();
        was_drain = m_burst && m_last;
        ufset     = m_burst && !m_last && lanes_ready && (mq.size() < m_n);
        e_data    = '0;
        e_valid   = '0;
        for (int i = 0; i < d; i++) begin
            e_data[8*i +: 8] = mq.pop_front();
            e_valid[i]       = 1'b1;
        end
        fin = was_drain && (mq.size() == 0);
        if (fin) begin
            m_burst = 0;
            m_last  = 0;
`ifdef DSI_DISTR_STATS_EN
            if (m_bursts < 65535) m_bursts++;
`endif
        end
        if (rd) begin
            for (int j = 0; j < int'(data_bytes); j++) begin
                mq.push_back(data_in[8*j +: 8]);
                sb.push_back(data_in[8*j +: 8]);
            end
            if (!m_burst) begin
                m_burst = 1;
                m_n     = int'(lanes_number) + 1;
            end
            if (data_last) m_last = 1;
        end
        e_hs       = (d > 0) || (e_hs && !m_fin_prev);
        m_fin_prev = fin;
        e_uf       = clear_underflow ? 1'b0 : (e_uf || ufset);
    endtask

    task automatic step();
        logic [7:0] exp_b;
        if (rnd_rdy) lanes_ready = ($urandom_range(0, 99) < 75);
        if (rnd_ln)  lanes_number = 2'($urandom_range(0, 3));
        if (rnd_clr) clear_underflow = ($urandom_range(0, 15) == 0);
        assert (!data_valid || (data_bytes >= 3'd1 && data_bytes <= 3'd4))
            else $error("illegal data_bytes %0d", data_bytes);
        @(negedge clk);
        exp_rd = m_read();
        obs_rd = data_read;
        n_cmp++;
        if (data_read !== exp_rd) begin
            n_err++;
            $display("FAIL data_read: got %b want %b", data_read, exp_rd);
        end
        @(posedge clk);
        m_clock();
        #1;
        n_cmp++;
        if (lane_valid !== e_valid) begin
            n_err++;
            $display("FAIL lane_valid: got %b want %b", lane_valid, e_valid);
        end
        n_cmp++;
        if (lane_data !== e_data) begin
            n_err++;
            $display("FAIL lane_data: got %08h want %08h", lane_data, e_data);
        end
        n_cmp++;
        if (hs_active !== e_hs) begin
            n_err++;
            $display("FAIL hs_active: got %b want %b", hs_active, e_hs);
        end
        n_cmp++;
        if (underflow !== e_uf) begin
            n_err++;
            $display("FAIL underflow: got %b want %b", underflow, e_uf);
        end
`ifdef DSI_DISTR_STATS_EN
        n_cmp++;
        if (burst_count !== 16'(m_bursts)) begin
            n_err++;
            $display("FAIL burst_count: got %0d want %0d", burst_count, m_bursts);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            if (lane_valid[i] === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL scoreboard: lane %0d got %02h want no byte", i, lane_data[8*i +: 8]);
                end else begin
                    exp_b = sb.pop_front();
                    if (lane_data[8*i +: 8] !== exp_b) begin
                        n_err++;
                        $display("FAIL scoreboard: lane %0d got %02h want %02h", i, lane_data[8*i +: 8], exp_b);
                    end
                end
            end
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
        int cyc = 0;
        data_in    = d;
        data_bytes = nb;
        data_last  = last;
        data_valid = 1'b1;
        do begin
            step();
            cyc++;
        end while (!exp_rd && cyc < 64);
        n_cmp++;
        if (!exp_rd) begin
            n_err++;
            $display("FAIL send_timeout: word %08h got no read want read within 64 cycles", d);
        end
        data_valid = 1'b0;
        data_last  = 1'b0;
    endtask

    task automatic drain_out();
        int cyc = 0;
        data_valid = 1'b0;
        while ((m_burst || e_hs) && cyc < 64) begin
            step();
            cyc++;
        end
        n_cmp++;
        if (m_burst || e_hs || sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d bytes outstanding want burst closed", sb.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        lanes_number = 2'd0; data_in = '0; data_bytes = 3'd1; data_last = 1'b0;
        data_valid = 1'b0; lanes_ready = 1'b0; clear_underflow = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        n_cmp++;
        if ({lane_data, lane_valid, hs_active, underflow, data_read} !== 39'd0) begin
            n_err++;
            $display("FAIL reset_state: got %08h/%b/%b/%b/%b want all 0",
                     lane_data, lane_valid, hs_active, underflow, data_read);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        lanes_ready = 1'b1;
        step();
        step();
    endtask

    task automatic test_four_lane();
        lanes_number = 2'd3;
        lanes_ready  = 1'b1;
        send_word(32'h03020100, 3'd4, 1'b0);
        send_word(32'h07060504, 3'd4, 1'b1);
        n_cmp++;
        if (lane_data !== 32'h03020100 || lane_valid !== 4'hF) begin
            n_err++;
            $display("FAIL four_lane_first: got %08h/%b want 03020100/1111", lane_data, lane_valid);
        end
        step();
        n_cmp++;
        if (lane_data !== 32'h07060504 || lane_valid !== 4'hF) begin
            n_err++;
            $display("FAIL four_lane_second: got %08h/%b want 07060504/1111", lane_data, lane_valid);
        end
        drain_out();
        n_cmp++;
        if (hs_active !== 1'b0 || underflow !== 1'b0) begin
            n_err++;
            $display("FAIL four_lane_end: got hs=%b uf=%b want 0/0", hs_active, underflow);
        end
    endtask

    task automatic test_two_lane();
        lanes_number = 2'd1;
        send_word(32'hDDCCBBAA, 3'd4, 1'b0);
        send_word(32'h00000011, 3'd1, 1'b1);
        n_cmp++;
        if (lane_data !== 32'h0000BBAA || lane_valid !== 4'b0011) begin
            n_err++;
            $display("FAIL two_lane_1: got %08h/%b want 0000BBAA/0011", lane_data, lane_valid);
        end
        step();
        n_cmp++;
        if (lane_data !== 32'h0000DDCC || lane_valid !== 4'b0011) begin
            n_err++;
            $display("FAIL two_lane_2: got %08h/%b want 0000DDCC/0011", lane_data, lane_valid);
        end
        step();
        n_cmp++;
        if (lane_data !== 32'h00000011 || lane_valid !== 4'b0001) begin
            n_err++;
            $display("FAIL two_lane_3: got %08h/%b want 00000011/0001", lane_data, lane_valid);
        end
        drain_out();
    endtask

    task automatic test_underflow();
        lanes_number = 2'd3;
        send_word(32'h44332211, 3'd4, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (lane_valid !== 4'h0 || underflow !== 1'b1) begin
                n_err++;
                $display("FAIL starved_%0d: got valid=%b uf=%b want 0000/1", k, lane_valid, underflow);
            end
        end
        send_word(32'h88776655, 3'd4, 1'b1);
        drain_out();
        n_cmp++;
        if (underflow !== 1'b1) begin
            n_err++;
            $display("FAIL underflow_sticky: got %b want 1", underflow);
        end
        clear_underflow = 1'b1;
        step();
        clear_underflow = 1'b0;
        n_cmp++;
        if (underflow !== 1'b0) begin
            n_err++;
            $display("FAIL underflow_clear: got %b want 0", underflow);
        end
    endtask

    task automatic test_ready_stall();
        lanes_number = 2'd0;
        lanes_ready  = 1'b0;
        send_word(32'hA3A2A1A0, 3'd4, 1'b0);
        send_word(32'hA7A6A5A4, 3'd4, 1'b0);
        data_in = 32'hABAAA9A8; data_bytes = 3'd4; data_last = 1'b0; data_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if (obs_rd !== 1'b0 || lane_valid !== 4'h0) begin
                n_err++;
                $display("FAIL stall_%0d: got read=%b valid=%b want 0/0000", k, obs_rd, lane_valid);
            end
        end
        lanes_ready = 1'b1;
        send_word(32'hABAAA9A8, 3'd4, 1'b0);
        send_word(32'h00ADACAB, 3'd3, 1'b1);
        drain_out();
    endtask

    task automatic test_lane_change();
        lanes_number = 2'd3;
        send_word(32'hB3B2B1B0, 3'd4, 1'b0);
        lanes_number = 2'd0;
        send_word(32'hB7B6B5B4, 3'd4, 1'b0);
        n_cmp++;
        if (lane_valid !== 4'hF) begin
            n_err++;
            $display("FAIL lane_latch: got %b want 1111", lane_valid);
        end
        send_word(32'hBBBAB9B8, 3'd4, 1'b1);
        drain_out();
        send_word(32'hC3C2C1C0, 3'd4, 1'b1);
        step();
        n_cmp++;
        if (lane_valid !== 4'b0001 || lane_data !== 32'h000000C0) begin
            n_err++;
            $display("FAIL one_lane: got %08h/%b want 000000C0/0001", lane_data, lane_valid);
        end
        drain_out();
    endtask

    task automatic test_reset_mid();
        lanes_number = 2'd1;
        send_word(32'hD3D2D1D0, 3'd4, 1'b0);
        send_word(32'hD7D6D5D4, 3'd4, 1'b0);
        data_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({lane_data, lane_valid, hs_active, underflow, data_read} !== 39'd0) begin
            n_err++;
            $display("FAIL reset_mid: got %08h/%b/%b/%b/%b want all 0",
                     lane_data, lane_valid, hs_active, underflow, data_read);
        end
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step();
        send_word(32'hE3E2E1E0, 3'd4, 1'b0);
        send_word(32'h0000E5E4, 3'd2, 1'b1);
        drain_out();
    endtask

    task automatic test_random();
        int nw;
        rnd_rdy = 1; rnd_ln = 1; rnd_clr = 1;
        for (int b = 0; b < 40; b++) begin
            nw = $urandom_range(1, 6);
            for (int w = 0; w < nw; w++) begin
                if ($urandom_range(0, 3) == 0) begin
                    data_valid = 1'b0;
                    step();
                end
                send_word($urandom, 3'($urandom_range(1, 4)), w == nw - 1);
            end
            drain_out();
        end
        rnd_rdy = 0; rnd_ln = 0; rnd_clr = 0;
        lanes_ready = 1'b1;
        clear_underflow = 1'b1;
        step();
        clear_underflow = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_four_lane();
        test_two_lane();
        test_underflow();
        test_ready_stall();
        test_lane_change();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
